// File: rtl/req_slice_pkg.sv
// req_slice_pkg: shared bus types, FSM state encoding and field-width helpers for req_slice.
package req_slice_pkg;

    // BUS_D carries {valid, addr, wdata, wstrb}; BUS_I carries {valid, addr}.
    typedef enum logic {
        BUS_I = 1'b0,
        BUS_D = 1'b1
    } bus_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Response layout is {rdata, ready}.
    localparam int RESP_READY_BIT = 0;

    function automatic int req_w(bus_type_e t, int aw, int dw);
        return 1 + aw + ((t == BUS_D) ? dw + dw / 8 : 0);
    endfunction

    function automatic int resp_w(int dw);
        return dw + 1;
    endfunction

    // valid is always the MSB of a request.
    function automatic int req_valid_bit(bus_type_e t, int aw, int dw);
        return req_w(t, aw, dw) - 1;
    endfunction

endpackage

// File: rtl/req_slice_wdog.sv
// req_slice_wdog: saturating access watchdog counter.
//   clk, rst (async active-low) : clock and reset
//   clr                         : restart the count at zero (wins over en)
//   en                          : advance the count by one
//   expired                     : count has reached its all-ones value
module req_slice_wdog #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt;

    assign expired = &cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/req_slice.sv
// req_slice: registered single-outstanding-transaction slice between merge and a shared slave.
//   clk     : clock
//   rst     : asynchronous active-low reset
//   m_req   : request from merge, valid in the MSB
//   m_resp  : registered response to merge, {rdata, ready}
//   s_req   : registered request held stable towards the slave
//   s_resp  : slave response, {rdata, ready}
//   timeout : one-cycle pulse alongside a watchdog-aborted response
module req_slice
    import req_slice_pkg::*;
#(
    parameter bus_type_e TYPE      = BUS_D,
    parameter int        ADDR_W    = 32,
    parameter int        DATA_W    = 32,
    parameter int        TIMEOUT_W = 8,
    localparam int       REQ_W     = req_w(TYPE, ADDR_W, DATA_W),
    localparam int       RESP_W    = resp_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  m_req,
    output logic [RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]  s_req,
    input  logic [RESP_W-1:0] s_resp,
    output logic              timeout
);

    localparam int VALID = req_valid_bit(TYPE, ADDR_W, DATA_W);

    state_e state;
    logic   expired;
    logic   s_ready;

    assign s_ready = s_resp[RESP_READY_BIT];

    generate
        if (TIMEOUT_W > 0) begin : g_wdog
            req_slice_wdog #(.W(TIMEOUT_W)) u_wdog (
                .clk     (clk),
                .rst     (rst),
                .clr     (state == IDLE && m_req[VALID]),
                .en      (state == BUSY && !s_ready),
                .expired (expired)
            );
        end else begin : g_no_wdog
            assign expired = 1'b0;
        end
    endgenerate

    // s_req is the request register itself, so the slave sees a frozen copy
    // of the accepted request and reset clears valid without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            s_req   <= '0;
            m_resp  <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req[VALID]) begin
                        s_req <= m_req;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // A real slave answer takes priority over a same-cycle expiry.
                    if (s_ready) begin
                        s_req[VALID] <= 1'b0;
                        m_resp       <= {s_resp[RESP_W-1:1], 1'b1};
                        state        <= RESP;
                    end else if (expired) begin
                        s_req[VALID] <= 1'b0;
                        m_resp       <= {{DATA_W{1'b1}}, 1'b1};
                        timeout      <= 1'b1;
                        state        <= RESP;
                    end
                end
                default: begin
                    m_resp  <= '0;
                    timeout <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_slice.sv
module tb_req_slice;
    import req_slice_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [REQ_W-1:0]  m_req = '0;
    logic [RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]  s_req;
    logic [RESP_W-1:0] s_resp = '0;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    req_slice #(
        .TYPE      (BUS_D),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TIMEOUT_W (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_resp  (m_resp),
        .s_req   (s_req),
        .s_resp  (s_resp),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] mk_req(logic v, logic [31:0] a, logic [31:0] wd, logic [3:0] ws);
        return {v, a, wd, ws};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(logic [31:0] rd, logic rdy);
        return {rd, rdy};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_s_req", s_req, 0);
        check("rst_m_resp", m_resp, 0);
        check("rst_timeout", timeout, 0);
        sample();
        rst = 1'b1;

        // Single read: cycle 0 request, slave ready at cycle 1, response at cycle 2
        step();
        m_req = mk_req(1, 32'h100, 0, 0);
        sample();
        check("rd_c0_valid", s_req[REQ_W-1], 0);
        step();
        m_req  = '0;
        s_resp = mk_resp(32'hCAFEF00D, 1);
        sample();
        check("rd_c1_s_req", s_req, mk_req(1, 32'h100, 0, 0));
        check("rd_c1_m_resp", m_resp, 0);
        step();
        s_resp = '0;
        sample();
        check("rd_c2_m_resp", m_resp, mk_resp(32'hCAFEF00D, 1));
        check("rd_c2_valid", s_req[REQ_W-1], 0);
        check("rd_c2_timeout", timeout, 0);
        step();
        sample();
        check("rd_c3_m_resp", m_resp, 0);

        // Stalled write: slave ready at cycle 5, m_req addr changes mid-access
        step();
        m_req = mk_req(1, 32'h8, 32'h55AA, 4'hF);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 2) m_req = mk_req(1, 32'h20, 32'h55AA, 4'hF);
            if (c == 5) begin
                m_req  = '0;
                s_resp = mk_resp(32'h600D, 1);
            end
            sample();
            check($sformatf("wr_c%0d_s_req", c), s_req, mk_req(1, 32'h8, 32'h55AA, 4'hF));
            check($sformatf("wr_c%0d_m_resp", c), m_resp, 0);
        end
        step();
        s_resp = '0;
        sample();
        check("wr_c6_m_resp", m_resp, mk_resp(32'h600D, 1));
        check("wr_c6_valid", s_req[REQ_W-1], 0);
        step();
        sample();
        check("wr_c7_m_resp", m_resp, 0);

        // Watchdog: slave never ready, 8 BUSY cycles then aborted response
        step();
        m_req = mk_req(1, 32'h40, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            step();
            m_req = '0;
            sample();
            check($sformatf("wd_c%0d_valid", c), s_req[REQ_W-1], 1);
            check($sformatf("wd_c%0d_timeout", c), timeout, 0);
        end
        step();
        sample();
        check("wd_c9_valid", s_req[REQ_W-1], 0);
        check("wd_c9_m_resp", m_resp, mk_resp(32'hFFFFFFFF, 1));
        check("wd_c9_timeout", timeout, 1);
        step();
        sample();
        check("wd_c10_m_resp", m_resp, 0);
        check("wd_c10_timeout", timeout, 0);

        // Race: slave ready exactly on the expiry cycle wins
        step();
        m_req = mk_req(1, 32'h44, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            step();
            m_req = '0;
            if (c == 8) s_resp = mk_resp(32'h1234, 1);
        end
        step();
        s_resp = '0;
        sample();
        check("race_m_resp", m_resp, mk_resp(32'h1234, 1));
        check("race_timeout", timeout, 0);
        step();

        // Reset mid-access: valid drops without a clock edge, no response afterwards
        m_req = mk_req(1, 32'h80, 0, 0);
        step();
        m_req = '0;
        sample();
        check("rst_mid_busy", s_req[REQ_W-1], 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_async_valid", s_req[REQ_W-1], 0);
        step();
        sample();
        rst    = 1'b1;
        s_resp = mk_resp(32'hDEAD, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            sample();
            check($sformatf("rst_post_c%0d_m_resp", c), m_resp, 0);
            check($sformatf("rst_post_c%0d_valid", c), s_req[REQ_W-1], 0);
        end
        s_resp = '0;
        step();
        m_req = mk_req(1, 32'h200, 0, 0);
        step();
        m_req  = '0;
        s_resp = mk_resp(32'hBEEF, 1);
        sample();
        check("rst_next_s_req", s_req, mk_req(1, 32'h200, 0, 0));
        step();
        s_resp = '0;
        sample();
        check("rst_next_m_resp", m_resp, mk_resp(32'hBEEF, 1));
        step();

        // Back-to-back: valid held, slave always ready
        s_resp = mk_resp(32'h11110000, 1);
        m_req  = mk_req(1, 32'h0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 2) m_req = mk_req(1, 32'h4, 0, 0);
            if (c == 4) m_req = '0;
            sample();
            check($sformatf("b2b_c%0d_valid", c), s_req[REQ_W-1], (c == 1 || c == 4));
            check($sformatf("b2b_c%0d_m_resp", c), m_resp,
                  (c == 2 || c == 5) ? mk_resp(32'h11110000, 1) : '0);
            if (c == 1) check("b2b_c1_addr", s_req[REQ_W-2 -: 32], 32'h0);
            if (c == 4) check("b2b_c4_addr", s_req[REQ_W-2 -: 32], 32'h4);
        end
        s_resp = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
